video_pattern_gen: RTL

Synthesizable parallel-video source that drives the same `di`/`de`/`hs`/`vs` interface the simulation monitor captures. It produces programmable raster timing (sync, back porch, active, front porch) and a selectable test pattern. It sits at the head of the video filter chain, and feeds filters or the monitor directly in benches and on hardware bring-up.

---
 rtl/video_pattern_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/video_pattern_gen.sv
// Parallel-video test source: programmable raster timing plus four selectable patterns.
// Outputs are registered one clock behind the hcnt/vcnt state that produces them.
module video_pattern_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [1:0]            pattern_i,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  sof_o,
  output logic [15:0]           frame_o
);

  localparam logic [15:0] H_TOTAL = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [15:0] V_TOTAL = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [15:0] H_SYN   = 16'(H_SYNC);
  localparam logic [15:0] V_SYN   = 16'(V_SYNC);
  localparam logic [15:0] H_ACT_S = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_ACT_E = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_ACT_S = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_ACT_E = 16'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [15:0] hcnt, vcnt;
  logic [1:0]  pat_q;
  logic [7:0]  frm_q;
  logic        h_last, v_last, frame_end, frame_start;
  logic        h_act, v_act, de_c;
  logic [7:0]  x, y, p;

  assign h_last      = (hcnt == H_TOTAL - 16'd1);
  assign v_last      = (vcnt == V_TOTAL - 16'd1);
  assign frame_end   = (state_q == RUN) && h_last && v_last;
  assign frame_start = (hcnt == 16'd0) && (vcnt == 16'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (frame_end && !en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counters sit at 0 in IDLE so the first RUN cycle is already the frame origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt    <= '0;
      vcnt    <= '0;
      frame_o <= '0;
    end else if (state_q == RUN) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? 16'd0 : vcnt + 16'd1;
      end else begin
        hcnt <= hcnt + 16'd1;
      end
      if (frame_end) frame_o <= frame_o + 16'd1;
    end else begin
      hcnt <= '0;
      vcnt <= '0;
    end
  end

  // Pattern select and the diagonal's frame offset are frozen for a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      frm_q <= '0;
    end else if (frame_start) begin
      pat_q <= pattern_i;
      frm_q <= frame_o[7:0];
    end
  end

  assign h_act = (hcnt >= H_ACT_S) && (hcnt < H_ACT_E);
  assign v_act = (vcnt >= V_ACT_S) && (vcnt < V_ACT_E);
  assign de_c  = h_act && v_act;
  assign x     = 8'(hcnt - H_ACT_S);
  assign y     = 8'(vcnt - V_ACT_S);

  always_comb begin
    p = 8'h00;
    case (pat_q)
      2'd0: p = x;
      2'd1: p = y;
      2'd2: p = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      2'd3: p = x + y + frm_q;
      default: p = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_o  <= '0;
      de_o  <= 1'b0;
      hs_o  <= 1'b0;
      vs_o  <= 1'b0;
      sof_o <= 1'b0;
    end else if (state_q == RUN) begin
      do_o  <= de_c ? DATA_WIDTH'(p) : '0;
      de_o  <= de_c;
      hs_o  <= (hcnt < H_SYN);
      vs_o  <= (vcnt < V_SYN);
      sof_o <= frame_start;
    end else begin
      do_o  <= '0;
      de_o  <= 1'b0;
      hs_o  <= 1'b0;
      vs_o  <= 1'b0;
      sof_o <= 1'b0;
    end
  end

endmodule
